counter_updown_mod: RTL and testbench
=====================================

# counter_updown_mod

Parametrised up/down modulo counter with prescaler, synchronous load/clear and terminal-count flagging. Generalises the fixed 8-bit enable counter to arbitrary width, modulus, count direction and wrap/saturate mode. Used as the shared event/timer counter in the design and as the next formal/simulation target in the counter suite.

## Interface

- WIDTH, 8, counter width in bits (1..32)
- MAX, 2**WIDTH-1, terminal value; count range is 0..MAX (1 <= MAX <= 2**WIDTH-1)
- SATURATE, 0, 0 = wrap at bounds, 1 = hold at bounds
- PRESCALE, 1, qualified enable strobes per count step (1..256)

- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  asynchronous, active-low reset
- clear  input  1  synchronous clear to 0
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  load value
- ena  input  1  count enable strobe
- up  input  1  direction: 1 = increment, 0 = decrement
- result  output  WIDTH  current count, registered
- tc  output  1  terminal-count pulse, registered
- at_max  output  1  result == MAX (decode of registered result)
- at_zero  output  1  result == 0 (decode of registered result)

## Operation

- Internal prescale counter pre_cnt, range 0..PRESCALE-1; PRESCALE = 1 means every ena is a step.
- Per-edge priority: clear > load > ena.
  - clear: result <= 0, pre_cnt <= 0, tc <= 0.
  - load (no clear): result <= min(load_val, MAX), pre_cnt <= 0, tc <= 0.
  - ena (no clear/load): if pre_cnt == PRESCALE-1, perform a step and pre_cnt <= 0; else pre_cnt <= pre_cnt+1, result holds, tc <= 0.
  - none asserted: result and pre_cnt hold, tc <= 0.
- Step, up = 1: result < MAX -> result+1, tc <= 0; result == MAX -> 0 (SATURATE = 0) or hold at MAX (SATURATE = 1), tc <= 1 in both modes.
- Step, up = 0: result > 0 -> result-1, tc <= 0; result == 0 -> MAX (SATURATE = 0) or hold at 0 (SATURATE = 1), tc <= 1.
- up is sampled only on the step cycle. Changing up mid-prescale does not reset pre_cnt.
- All arithmetic is WIDTH bits. MAX < 2**WIDTH-1 never yields values above MAX; wrap uses MAX, not 2**WIDTH-1.
- Illegal parameters (MAX = 0, MAX > 2**WIDTH-1, PRESCALE = 0) stop elaboration with an error.

## Timing

- reset low: result = 0, pre_cnt = 0, tc = 0 immediately, independent of clk. at_zero = 1, at_max = 0 (at_max = 1 only if MAX = 0, which is illegal).
- reset deassertion is synchronised externally; the first active edge after release behaves as a normal cycle.
- Latency: a step is visible on result one cycle after the qualifying ena edge. tc is high for exactly that cycle, coincident with the wrapped/held value.
- tc never stays high two consecutive cycles unless consecutive steps each hit a bound. This happens with PRESCALE = 1, SATURATE = 1 and ena held at the bound.
- Reset asserted mid-prescale discards pre_cnt. Clear/load in the same cycle as a step suppress that step and its tc.
- at_max / at_zero are pure decodes of result, with no extra latency.

## Test plan

- Reset: assert reset low mid-count at result = 0x37 -> result = 0x00 and tc = 0 before the next clk edge; at_zero = 1.
- Wrap up, WIDTH = 8, MAX = 9, SATURATE = 0, PRESCALE = 1, up = 1, ena held 10 cycles from 0 -> result 1..9 then 0; tc = 1 only in the cycle result = 0.
- Saturate down, MAX = 9, SATURATE = 1, load 2, up = 0, ena 4 cycles -> result 1, 0, 0, 0; tc = 0, 0, 1, 1.
- Prescale, PRESCALE = 3, up = 1, ena pulsed 7 times from 0 -> result 0, 0, 1, 1, 1, 2, 2; a load of 5 after the 7th pulse resets pre_cnt, so 3 more ena give result 6.
- Priority, clear = load = ena = 1 with load_val = 4 at result = 7 -> result = 0; load = ena = 1 with load_val = 200 and MAX = 9 -> result = 9, tc = 0.
- Direction change, PRESCALE = 2 at result = 5: ena with up = 1, then ena with up = 0 -> result = 4 (up sampled at the step); at_zero/at_max track the decode every cycle.

Source files
------------

// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with prescaler, synchronous clear/load
// and a registered terminal-count pulse on each bound hit.
module counter_updown_mod #(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE = 1'b0,
    parameter int              PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ena,
    input  logic             up,
    output logic [WIDTH-1:0] result,
    output logic             tc,
    output logic             at_max,
    output logic             at_zero
);

    localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_V    = MAX[WIDTH-1:0];
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    generate
        if (WIDTH < 1 || WIDTH > 32 || MAX == 0 || MAX > ((64'd1 << WIDTH) - 64'd1) ||
            PRESCALE < 1 || PRESCALE > 256) begin : g_bad_params
            $error("counter_updown_mod: illegal parameter set");
        end
    endgenerate

    logic [WIDTH-1:0] result_q, result_d;
    logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
    logic             tc_q, tc_d;

    always_comb begin
        result_d  = result_q;
        pre_cnt_d = pre_cnt_q;
        tc_d      = 1'b0;
        if (clear) begin
            result_d  = '0;
            pre_cnt_d = '0;
        end else if (load) begin
            result_d  = (load_val > MAX_V) ? MAX_V : load_val;
            pre_cnt_d = '0;
        end else if (ena) begin
            if (pre_cnt_q == PRE_LAST) begin
                pre_cnt_d = '0;
                // direction is only looked at on the step itself
                if (up) begin
                    if (result_q == MAX_V) begin
                        tc_d     = 1'b1;
                        result_d = SATURATE ? MAX_V : '0;
                    end else begin
                        result_d = result_q + WIDTH'(1);
                    end
                end else begin
                    if (result_q == '0) begin
                        tc_d     = 1'b1;
                        result_d = SATURATE ? '0 : MAX_V;
                    end else begin
                        result_d = result_q - WIDTH'(1);
                    end
                end
            end else begin
                pre_cnt_d = pre_cnt_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q  <= '0;
            pre_cnt_q <= '0;
            tc_q      <= 1'b0;
        end else begin
            result_q  <= result_d;
            pre_cnt_q <= pre_cnt_d;
            tc_q      <= tc_d;
        end
    end

    assign result  = result_q;
    assign tc      = tc_q;
    assign at_max  = (result_q == MAX_V);
    assign at_zero = (result_q == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: several parameter sets share one
// stimulus stream; each section checks the instance it targets.
module tb_counter_updown_mod;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       ena = 1'b0;
    logic       up = 1'b1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    logic [7:0] r_def, r_wrap, r_sat, r_pre3, r_pre2;
    logic tc_def, tc_wrap, tc_sat, tc_pre3, tc_pre2;
    logic mx_def, mx_wrap, mx_sat, mx_pre3, mx_pre2;
    logic zr_def, zr_wrap, zr_sat, zr_pre3, zr_pre2;

    counter_updown_mod u_def (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .ena(ena), .up(up), .result(r_def), .tc(tc_def), .at_max(mx_def), .at_zero(zr_def));

    counter_updown_mod #(.WIDTH(8), .MAX(9), .SATURATE(1'b0), .PRESCALE(1)) u_wrap (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .ena(ena), .up(up), .result(r_wrap), .tc(tc_wrap), .at_max(mx_wrap), .at_zero(zr_wrap));

    counter_updown_mod #(.WIDTH(8), .MAX(9), .SATURATE(1'b1), .PRESCALE(1)) u_sat (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .ena(ena), .up(up), .result(r_sat), .tc(tc_sat), .at_max(mx_sat), .at_zero(zr_sat));

    counter_updown_mod #(.WIDTH(8), .PRESCALE(3)) u_pre3 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .ena(ena), .up(up), .result(r_pre3), .tc(tc_pre3), .at_max(mx_pre3), .at_zero(zr_pre3));

    counter_updown_mod #(.WIDTH(8), .PRESCALE(2)) u_pre2 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .ena(ena), .up(up), .result(r_pre2), .tc(tc_pre2), .at_max(mx_pre2), .at_zero(zr_pre2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // inputs are applied before the edge; outputs sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear = 1'b0; load = 1'b0; ena = 1'b0;
    endtask

    initial begin
        int exp_w [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
        int exp_s [4]  = '{1, 0, 0, 0};
        int exp_st[4]  = '{0, 0, 1, 1};
        int exp_p [7]  = '{0, 0, 1, 1, 1, 2, 2};
        int exp_pl[3]  = '{5, 5, 6};

        // reset held low from time 0
        #2;
        check("rst_result", r_def, 0);
        check("rst_tc", tc_def, 0);
        check("rst_at_zero", zr_def, 1);
        check("rst_at_max", mx_wrap, 0);
        @(negedge clk);
        reset = 1'b1;

        // reset asserted mid-count at 0x37
        load = 1'b1; load_val = 8'h37;
        tick();
        idle_inputs();
        check("pre_rst_result", r_def, 8'h37);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_result", r_def, 0);
        check("async_rst_tc", tc_def, 0);
        check("async_rst_at_zero", zr_def, 1);
        @(negedge clk);
        reset = 1'b1;

        // wrap up on MAX = 9
        clear = 1'b1;
        tick();
        clear = 1'b0; ena = 1'b1; up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("wrap_result_%0d", i), r_wrap, exp_w[i]);
            check($sformatf("wrap_tc_%0d", i), tc_wrap, (i == 9) ? 1 : 0);
            check($sformatf("wrap_at_max_%0d", i), mx_wrap, (i == 8) ? 1 : 0);
        end
        idle_inputs();

        // saturate down from 2
        load = 1'b1; load_val = 8'd2;
        tick();
        check("sat_load", r_sat, 2);
        load = 1'b0; ena = 1'b1; up = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("sat_result_%0d", i), r_sat, exp_s[i]);
            check($sformatf("sat_tc_%0d", i), tc_sat, exp_st[i]);
        end
        idle_inputs();

        // prescale by 3, then a load restarts the prescaler
        clear = 1'b1;
        tick();
        clear = 1'b0; up = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ena = 1'b1;
            tick();
            check($sformatf("pre3_result_%0d", i), r_pre3, exp_p[i]);
            check($sformatf("pre3_tc_%0d", i), tc_pre3, 0);
        end
        ena = 1'b0; load = 1'b1; load_val = 8'd5;
        tick();
        load = 1'b0;
        check("pre3_load", r_pre3, 5);
        for (int i = 0; i < 3; i++) begin
            ena = 1'b1;
            tick();
            check($sformatf("pre3_after_load_%0d", i), r_pre3, exp_pl[i]);
        end
        idle_inputs();

        // priority on MAX = 9
        load = 1'b1; load_val = 8'd7;
        tick();
        check("prio_setup", r_wrap, 7);
        clear = 1'b1; load = 1'b1; ena = 1'b1; load_val = 8'd4; up = 1'b1;
        tick();
        check("prio_clear_wins", r_wrap, 0);
        clear = 1'b0; load = 1'b1; ena = 1'b1; load_val = 8'd200;
        tick();
        check("prio_load_clamp", r_wrap, 9);
        check("prio_load_tc", tc_wrap, 0);
        // at MAX, a load beats a wrapping step and its tc
        tick();
        check("prio_step_suppressed", r_wrap, 9);
        check("prio_tc_suppressed", tc_wrap, 0);
        idle_inputs();

        // direction change mid-prescale, PRESCALE = 2
        load = 1'b1; load_val = 8'd5;
        tick();
        load = 1'b0;
        check("dir_load", r_pre2, 5);
        ena = 1'b1; up = 1'b1;
        tick();
        check("dir_hold", r_pre2, 5);
        check("dir_hold_zero", zr_pre2, 0);
        check("dir_hold_max", mx_pre2, 0);
        up = 1'b0;
        tick();
        check("dir_step_down", r_pre2, 4);
        check("dir_step_tc", tc_pre2, 0);
        check("dir_step_zero", zr_pre2, 0);
        check("dir_step_max", mx_pre2, 0);
        ena = 1'b0; load = 1'b1; load_val = 8'd255;
        tick();
        check("dir_at_max", mx_pre2, 1);
        check("dir_at_max_zero", zr_pre2, 0);
        load_val = 8'd0;
        tick();
        check("dir_at_zero", zr_pre2, 1);
        check("dir_at_zero_max", mx_pre2, 0);
        // down from 0 with default MAX wraps to 255 on the second strobe
        load = 1'b0; ena = 1'b1; up = 1'b0;
        tick();
        check("dir_wrap_hold", r_pre2, 0);
        tick();
        check("dir_wrap_result", r_pre2, 255);
        check("dir_wrap_tc", tc_pre2, 1);
        ena = 1'b0;
        tick();
        check("dir_tc_drop", tc_pre2, 0);
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
